// File: rtl/lmsm_pkg.sv
// Shared definitions for the LM/SM sequencer: state encoding, sizes and
// the mask-bit to architectural-register mapping.
package lmsm_pkg;

    localparam int unsigned LMSM_MASK_W = 8;
    localparam int unsigned LMSM_IDX_W  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Mask bit i names register R(7-i), so the highest set bit is the lowest register.
    function automatic logic [LMSM_IDX_W-1:0] bit_to_reg(input logic [LMSM_IDX_W-1:0] b);
        return LMSM_IDX_W'(LMSM_MASK_W - 1) - b;
    endfunction

endpackage

// File: rtl/lmsm_pick.sv
// Combinational selector: picks the next register from the remaining mask
// (highest set bit first) and reports the bit to clear and last/zero flags.
module lmsm_pick
    import lmsm_pkg::*;
#(
    parameter int unsigned MASK_W = LMSM_MASK_W,
    parameter int unsigned IDX_W  = LMSM_IDX_W
) (
    input  logic [MASK_W-1:0] mask,
    output logic [IDX_W-1:0]  idx,
    output logic [MASK_W-1:0] clr,
    output logic              last,
    output logic              zero
);

    logic [IDX_W-1:0] hi;

    always_comb begin
        hi  = '0;
        clr = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (mask[i]) begin
                hi = IDX_W'(i);
            end
        end
        clr[hi] = |mask;
        zero    = ~|mask;
        idx     = zero ? '0 : bit_to_reg(hi);
        last    = ~zero && ((mask & (mask - MASK_W'(1))) == '0);
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: captures mask/base/op from decode and issues one
// register-transfer micro-op per selected register, stalling decode meanwhile.
module lmsm_sequencer
    import lmsm_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned MASK_W = LMSM_MASK_W,
    parameter int unsigned IDX_W  = LMSM_IDX_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              IS_LM,
    input  logic [DATA_W-1:0] BASE_ADDR,
    input  logic [MASK_W-1:0] REG_MASK,
    input  logic              ADV,
    input  logic              FLUSH,
    output logic              UOP_VALID,
    output logic [IDX_W-1:0]  RF_IDX,
    output logic [DATA_W-1:0] MEM_ADDR,
    output logic              RF_WE,
    output logic              MEM_WE,
    output logic              LAST,
    output logic              STALL_OUT,
    output logic              DONE
);

    state_e            state_q, state_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic              op_q, op_d;
    logic              done_q, done_d;

    logic [IDX_W-1:0]  pick_idx;
    logic [MASK_W-1:0] pick_clr;
    logic              pick_last;
    logic              pick_zero;
    logic              run;

    lmsm_pick #(
        .MASK_W(MASK_W),
        .IDX_W (IDX_W)
    ) u_pick (
        .mask(mask_q),
        .idx (pick_idx),
        .clr (pick_clr),
        .last(pick_last),
        .zero(pick_zero)
    );

    assign run = (state_q == ST_RUN) && !pick_zero;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        op_d    = op_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START && !FLUSH) begin
                    if (|REG_MASK) begin
                        state_d = ST_RUN;
                        mask_d  = REG_MASK;
                        addr_d  = BASE_ADDR;
                        op_d    = IS_LM;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (FLUSH) begin
                    state_d = ST_IDLE;
                    mask_d  = '0;
                end else if (ADV) begin
                    mask_d = mask_q & ~pick_clr;
                    addr_d = addr_q + DATA_W'(1);
                    if (pick_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            op_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    // Stall drops in the cycle the final micro-op is accepted.
    always_comb begin
        UOP_VALID = run;
        RF_IDX    = run ? pick_idx : '0;
        MEM_ADDR  = run ? addr_q : '0;
        RF_WE     = run & op_q;
        MEM_WE    = run & ~op_q;
        LAST      = run & pick_last;
        STALL_OUT = ((state_q == ST_IDLE) & START & (|REG_MASK)) | (run & ~(ADV & pick_last));
        DONE      = done_q;
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer: exhaustive picker check, directed
// vector table, reset-mid-run sequence, and randomized run against a model.
module tb_lmsm_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic        IS_LM = 1'b0;
    logic [15:0] BASE_ADDR = '0;
    logic [7:0]  REG_MASK = '0;
    logic        ADV = 1'b0;
    logic        FLUSH = 1'b0;
    logic        UOP_VALID;
    logic [2:0]  RF_IDX;
    logic [15:0] MEM_ADDR;
    logic        RF_WE, MEM_WE, LAST, STALL_OUT, DONE;

    logic [7:0]  p_mask = '0;
    logic [2:0]  p_idx;
    logic [7:0]  p_clr;
    logic        p_last, p_zero;

    always #5 CLK = ~CLK;

    lmsm_sequencer #(.DATA_W(16), .MASK_W(8), .IDX_W(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .IS_LM(IS_LM),
        .BASE_ADDR(BASE_ADDR), .REG_MASK(REG_MASK), .ADV(ADV), .FLUSH(FLUSH),
        .UOP_VALID(UOP_VALID), .RF_IDX(RF_IDX), .MEM_ADDR(MEM_ADDR),
        .RF_WE(RF_WE), .MEM_WE(MEM_WE), .LAST(LAST), .STALL_OUT(STALL_OUT),
        .DONE(DONE)
    );

    lmsm_pick #(.MASK_W(8), .IDX_W(3)) u_pick (
        .mask(p_mask), .idx(p_idx), .clr(p_clr), .last(p_last), .zero(p_zero)
    );

    typedef struct {
        logic        start;
        logic        is_lm;
        logic [15:0] base;
        logic [7:0]  mask;
        logic        adv;
        logic        flush;
        logic [24:0] exp;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad = 0;

    // Model state: registers still to transfer (ascending), next address, op.
    int          m_regs[$];
    logic        m_active = 1'b0;
    logic [15:0] m_addr = '0;
    logic        m_op = 1'b0;
    logic        m_done = 1'b0;

    function automatic logic [24:0] pk(int u, int i, int a, int rw, int mw, int l, int s, int d);
        return {u[0], i[2:0], a[15:0], rw[0], mw[0], l[0], s[0], d[0]};
    endfunction

    function automatic logic [24:0] got();
        return {UOP_VALID, RF_IDX, MEM_ADDR, RF_WE, MEM_WE, LAST, STALL_OUT, DONE};
    endfunction

    task automatic check(input string name, input logic [24:0] exp);
        total++;
        if (got() !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h (uv idx addr rfwe memwe last stall done)",
                     name, $time, got(), exp);
        end
    endtask

    task automatic drive(input int st, input int lm, input int b, input int m, input int adv, input int fl);
        START     = st[0];
        IS_LM     = lm[0];
        BASE_ADDR = 16'(b);
        REG_MASK  = 8'(m);
        ADV       = adv[0];
        FLUSH     = fl[0];
    endtask

    task automatic add(input int st, input int lm, input int b, input int m, input int adv, input int fl,
                       input logic [24:0] e);
        vec_t v;
        v.start = st[0]; v.is_lm = lm[0]; v.base = 16'(b); v.mask = 8'(m);
        v.adv = adv[0]; v.flush = fl[0]; v.exp = e;
        vq.push_back(v);
    endtask

    // Apply inputs at the falling edge, check mid-low-phase, then advance a cycle.
    task automatic step(input int st, input int lm, input int b, input int m, input int adv, input int fl,
                        input logic [24:0] e, input string name);
        drive(st, lm, b, m, adv, fl);
        #1;
        check(name, e);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic logic [24:0] model_exp();
        logic last, stall;
        int   r;
        last  = m_active && (m_regs.size() == 1);
        stall = (!m_active && START && (REG_MASK != 0)) || (m_active && !(ADV && last));
        r     = m_active ? m_regs[0] : 0;
        return pk(int'(m_active), r, m_active ? int'(m_addr) : 0, int'(m_active && m_op),
                  int'(m_active && !m_op), int'(last), int'(stall), int'(m_done));
    endfunction

    task automatic model_step();
        logic nd;
        nd = 1'b0;
        if (m_active) begin
            if (FLUSH) begin
                m_active = 1'b0;
                m_regs.delete();
            end else if (ADV) begin
                void'(m_regs.pop_front());
                m_addr = m_addr + 16'd1;
                if (m_regs.size() == 0) begin
                    m_active = 1'b0;
                    nd = 1'b1;
                end
            end
        end else if (START && !FLUSH) begin
            if (REG_MASK == 0) begin
                nd = 1'b1;
            end else begin
                m_regs.delete();
                for (int r = 0; r < 8; r++) if (REG_MASK[7-r]) m_regs.push_back(r);
                m_addr   = BASE_ADDR;
                m_op     = IS_LM;
                m_active = 1'b1;
            end
        end
        m_done = nd;
    endtask

    localparam logic [24:0] Z = 25'h0;

    initial begin
        logic [24:0] e;
        logic [12:0] pe;
        int          first, cnt;

        // LM basic: R0@0x40, R2@0x41, R7@0x42; live IS_LM dropped after START
        add(1, 1, 'h0040, 'hA1, 1, 0, pk(0, 0, 0, 0, 0, 0, 1, 0));
        add(0, 0, 0, 0, 1, 0, pk(1, 0, 'h0040, 1, 0, 0, 1, 0));
        add(0, 0, 0, 0, 1, 0, pk(1, 2, 'h0041, 1, 0, 0, 1, 0));
        add(0, 0, 0, 0, 1, 0, pk(1, 7, 'h0042, 1, 0, 1, 0, 0));
        add(0, 0, 0, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, Z);
        // Backpressure SM, with a stray START while running
        add(1, 0, 'h0200, 'h18, 0, 0, pk(0, 0, 0, 0, 0, 0, 1, 0));
        add(0, 0, 0, 0, 0, 0, pk(1, 3, 'h0200, 0, 1, 0, 1, 0));
        add(1, 0, 'h7777, 'hFF, 0, 0, pk(1, 3, 'h0200, 0, 1, 0, 1, 0));
        add(0, 1, 0, 0, 1, 0, pk(1, 3, 'h0200, 0, 1, 0, 1, 0));
        add(0, 0, 0, 0, 1, 0, pk(1, 4, 'h0201, 0, 1, 1, 0, 0));
        add(0, 0, 0, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 1));
        // Zero mask
        add(1, 0, 'h1234, 'h00, 1, 0, Z);
        add(0, 0, 0, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, Z);
        // Address wrap
        add(1, 1, 'hFFFF, 'h03, 1, 0, pk(0, 0, 0, 0, 0, 0, 1, 0));
        add(0, 0, 0, 0, 1, 0, pk(1, 6, 'hFFFF, 1, 0, 0, 1, 0));
        add(0, 0, 0, 0, 1, 0, pk(1, 7, 'h0000, 1, 0, 1, 0, 0));
        add(0, 0, 0, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 1));
        // Flush after two accepts, then START discarded by FLUSH in IDLE
        add(1, 0, 'h0300, 'hFF, 1, 0, pk(0, 0, 0, 0, 0, 0, 1, 0));
        add(0, 0, 0, 0, 1, 0, pk(1, 0, 'h0300, 0, 1, 0, 1, 0));
        add(0, 0, 0, 0, 1, 0, pk(1, 1, 'h0301, 0, 1, 0, 1, 0));
        add(0, 0, 0, 0, 1, 1, pk(1, 2, 'h0302, 0, 1, 0, 1, 0));
        add(1, 0, 'h0400, 'h0F, 1, 1, pk(0, 0, 0, 0, 0, 0, 1, 0));
        add(0, 0, 0, 0, 1, 0, Z);
        add(0, 0, 0, 0, 1, 0, Z);

        #1;
        check("reset_state", Z);

        for (int m = 0; m < 256; m++) begin
            p_mask = 8'(m);
            #1;
            first = 0;
            cnt   = 0;
            for (int r = 7; r >= 0; r--) if (p_mask[7-r]) first = r;
            for (int b = 0; b < 8; b++) if (p_mask[b]) cnt++;
            pe = {3'(first), (cnt != 0) ? 8'(1 << (7 - first)) : 8'h00, cnt == 1, cnt == 0};
            total++;
            if ({p_idx, p_clr, p_last, p_zero} !== pe) begin
                bad++;
                $display("FAIL pick mask=%h got=%h exp=%h", p_mask, {p_idx, p_clr, p_last, p_zero}, pe);
            end
        end

        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int k = 0; k < vq.size(); k++) begin
            step(vq[k].start, vq[k].is_lm, vq[k].base, vq[k].mask, vq[k].adv, vq[k].flush,
                 vq[k].exp, $sformatf("vec%0d", k));
        end

        // Async reset after two accepts, then a fresh sequence starts at R0
        step(1, 0, 'h0100, 'hFF, 1, 0, pk(0, 0, 0, 0, 0, 0, 1, 0), "rst_start");
        step(0, 0, 0, 0, 1, 0, pk(1, 0, 'h0100, 0, 1, 0, 1, 0), "rst_acc0");
        step(0, 0, 0, 0, 1, 0, pk(1, 1, 'h0101, 0, 1, 0, 1, 0), "rst_acc1");
        drive(0, 0, 0, 0, 1, 0);
        RST_N = 1'b0;
        #1;
        check("rst_immediate", Z);
        @(posedge CLK);
        #1;
        check("rst_no_done", Z);
        @(negedge CLK);
        RST_N = 1'b1;
        step(0, 0, 0, 0, 1, 0, Z, "rst_idle");
        step(1, 1, 'h0500, 'hFF, 1, 0, pk(0, 0, 0, 0, 0, 0, 1, 0), "rst_restart");
        step(0, 0, 0, 0, 0, 0, pk(1, 0, 'h0500, 1, 0, 0, 1, 0), "rst_r0");
        step(0, 0, 0, 0, 0, 1, pk(1, 0, 'h0500, 1, 0, 0, 1, 0), "rst_flush");
        step(0, 0, 0, 0, 0, 0, Z, "rst_end");

        for (int n = 0; n < 3000; n++) begin
            drive(int'($urandom_range(0, 99) < 30), int'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'(16'hFFFF - 16'($urandom_range(0, 3))) : int'($urandom_range(0, 65535)),
                  ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 99) < 70), int'($urandom_range(0, 99) < 4));
            #1;
            e = model_exp();
            check("rand", e);
            @(posedge CLK);
            model_step();
            @(negedge CLK);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
- Multi-cycle sequencer for the LM/SM (load/store multiple) instructions of the 16-bit RISC pipeline.
- Sits between decode and register-read/memory. Captures the 8-bit register mask and base address of an LM/SM instruction, then issues one register-transfer micro-op per selected register.
- Stalls fetch/decode until the last transfer is accepted.
- Register selection follows the team's LM/SM priority encoding: mask bit i selects register R(7-i), so transfers go in ascending register order.

Parameters:
- DATA_W, 16, address/base width
- MASK_W, 8, register-mask width (one bit per architectural register)
- IDX_W, 3, register index width (log2 MASK_W)

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  decode presents a valid LM/SM instruction this cycle
- IS_LM  in  1  1 = load multiple, 0 = store multiple; sampled with START
- BASE_ADDR  in  DATA_W  base address (RA contents); sampled with START
- REG_MASK  in  MASK_W  immediate register mask; sampled with START
- ADV  in  1  downstream accepts the current micro-op
- FLUSH  in  1  pipeline flush (branch redirect); aborts the sequence
- UOP_VALID  out  1  micro-op valid this cycle
- RF_IDX  out  IDX_W  register index of the current transfer
- MEM_ADDR  out  DATA_W  word address of the current transfer
- RF_WE  out  1  UOP_VALID & load
- MEM_WE  out  1  UOP_VALID & store
- LAST  out  1  current micro-op is the final one
- STALL_OUT  out  1  hold fetch/decode
- DONE  out  1  one-cycle pulse when the instruction retires from the sequencer

Behaviour:
- Reset (RST_N low, async): state IDLE; mask, address and op registers cleared; all outputs 0.
- States: IDLE, RUN.
- IDLE, START=1, REG_MASK!=0:
  - Capture mask, BASE_ADDR and IS_LM.
  - Go to RUN; first UOP_VALID on the next cycle, so latency is 1.
  - STALL_OUT=1 combinationally in the START cycle.
- IDLE, START=1, REG_MASK==0:
  - No transfers, no stall.
  - DONE=1 on the next cycle; stay IDLE.
- RUN:
  - UOP_VALID=1.
  - RF_IDX = 7 - (highest set bit index of the remaining mask).
  - MEM_ADDR = captured base + number of transfers already accepted.
  - LAST=1 when exactly one bit remains.
- Accept (UOP_VALID & ADV):
  - Clear only the selected mask bit.
  - Address += 1, mod 2^16: 0xFFFF wraps to 0x0000, no flag.
- ADV=0: hold all outputs stable; no mask or address change.
- Accept with LAST=1: next state IDLE; DONE=1 the following cycle.
- STALL_OUT = (IDLE & START & |REG_MASK) | (RUN & ~(ADV & LAST)). It drops in the cycle the last micro-op is accepted, so decode can advance the next cycle.
- START while RUN: ignored; decode is stalled, so it is a protocol error with no effect.
- FLUSH (priority over START and ADV):
  - Synchronous return to IDLE next cycle; mask cleared.
  - No DONE.
  - UOP_VALID still shows 1 in the FLUSH cycle; downstream qualifies it with FLUSH.
- FLUSH in IDLE together with START: START discarded.
- Async reset mid-sequence: immediate IDLE, outputs 0; no DONE.
- RF_WE/MEM_WE are derived from the registered op bit, never from live IS_LM.

Decomposition:
- Shared package `lmsm_pkg`:
  - state encoding (IDLE=1'b0, RUN=1'b1)
  - MASK_W/IDX_W constants
  - mask-bit-to-register mapping function (idx = 7 - bit)
- One natural sub-module, `lmsm_pick`, purely combinational:
  - Inputs: remaining mask.
  - Outputs: selected index, one-hot clear vector, last flag, zero flag.
  - Unit-tested separately.
- Sequencer owns the state, mask, address and op registers.

Test Plan:
- Reset mid-RUN: START, mask=0xFF, base=0x0100; assert RST_N=0 after 2 accepts -> outputs 0 immediately, no DONE; a new START after release works from R0.
- LM basic: START, IS_LM=1, mask=0xA1, base=0x0040, ADV=1 -> three micro-ops:
  - R0@0x0040, R2@0x0041, R7@0x0042
  - RF_WE=1, MEM_WE=0; LAST on the third; DONE next cycle
  - STALL_OUT high for 3 cycles
- Backpressure: SM, mask=0x18, ADV=0 for 2 cycles then 1 -> R3@base held stable 3 cycles, then R4@base+1; MEM_WE=1, RF_WE=0.
- Zero mask: START, mask=0x00 -> no UOP_VALID, STALL_OUT=0, DONE pulses 1 cycle later.
- Wrap: mask=0x03, base=0xFFFF -> R6@0xFFFF, R7@0x0000.
- FLUSH: mask=0xFF, FLUSH after 2 accepts -> IDLE next cycle, no DONE; START with FLUSH in the same cycle is discarded.
